// File: rtl/wbc_pkg.sv
// Shared definitions for the control-bus WISHBONE arbiter.
//   - wbc_state_e   : arbiter FSM encoding (IDLE / OWN / ABORT)
//   - WBC_NM/AW/TIMEOUT : default master count, address width, watchdog limit
//   - TERM_*        : bit positions inside the slave termination bundle
//   - sat_inc8      : saturating 8-bit increment used by the abort counter
package wbc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_ABORT = 2'd2
  } wbc_state_e;

  localparam int WBC_NM      = 4;
  localparam int WBC_AW      = 20;
  localparam int WBC_TIMEOUT = 255;

  // Termination bundle layout: {rty, err, ack}
  localparam int TERM_ACK = 0;
  localparam int TERM_ERR = 1;
  localparam int TERM_RTY = 2;
  localparam int TERM_W   = 3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wbc_arbiter_if.sv
// Control-bus signal bundle between the masters, the arbiter and the shared
// slave side.
//   m_* : per-master request fields (bit/slice k = master k) and the
//         broadcast read data / per-master terminations returned to them
//   s_* : the single shared-bus request and its termination
// Modports:
//   master : upstream masters (drive requests, receive terminations)
//   slave  : shared slave side (receive request, drive data/terminations)
//   arb    : the arbiter itself, sitting between the two
interface wbc_arbiter_if
  import wbc_pkg::*;
#(
  parameter int NM = WBC_NM,
  parameter int AW = WBC_AW
) ();

  logic [NM-1:0]    m_cyc_i;
  logic [NM-1:0]    m_stb_i;
  logic [NM-1:0]    m_we_i;
  logic [NM*AW-1:0] m_adr_i;
  logic [NM*32-1:0] m_dat_i;
  logic [NM*4-1:0]  m_sel_i;
  logic [31:0]      m_dat_o;
  logic [NM-1:0]    m_ack_o;
  logic [NM-1:0]    m_err_o;
  logic [NM-1:0]    m_rty_o;

  logic             s_cyc_o;
  logic             s_stb_o;
  logic             s_we_o;
  logic [AW-1:0]    s_adr_o;
  logic [31:0]      s_dat_o;
  logic [3:0]       s_sel_o;
  logic [31:0]      s_dat_i;
  logic             s_ack_i;
  logic             s_err_i;
  logic             s_rty_i;

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    input  m_dat_o, m_ack_o, m_err_o, m_rty_o
  );

  modport slave (
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    output s_dat_i, s_ack_i, s_err_i, s_rty_i
  );

  modport arb (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    output m_dat_o, m_ack_o, m_err_o, m_rty_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    input  s_dat_i, s_ack_i, s_err_i, s_rty_i
  );

endinterface

// File: rtl/wbc_rr_pick.sv
// Combinational round-robin selector.
// Searches req starting at (last+1) mod NM and returns the first requester.
//   req  : request vector, bit k = master k
//   last : index of the previous owner
//   gnt  : one-hot winner (0 when nobody requests)
//   idx  : binary index of the winner (0 when nobody requests)
//   any  : at least one request pending
module wbc_rr_pick
  import wbc_pkg::*;
#(
  parameter int NM = WBC_NM,
  localparam int IW = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic [NM-1:0] req,
  input  logic [IW-1:0] last,
  output logic [NM-1:0] gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic          found_s;
  logic [IW-1:0] cand_s;

  // Rotating priority scan: offset 1 is the master right after the last owner,
  // offset NM wraps back to the last owner itself (lowest priority).
  always_comb begin
    gnt     = '0;
    idx     = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int i = 1; i <= NM; i++) begin
      cand_s = IW'((int'(last) + i) % NM);
      if (!found_s && req[cand_s]) begin
        found_s     = 1'b1;
        idx         = cand_s;
        gnt[cand_s] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/wbc_arbiter.sv
// Round-robin arbiter, multiplexer and bus-timeout watchdog for the control
// WISHBONE bus. One master owns the shared bus for its whole CYC envelope;
// its request is muxed through combinationally and terminations are routed
// back only to it. An access the slave never terminates is aborted with ERR.
// Ports:
//   clk_i, rst_n_i : bus clock, asynchronous active-low reset
//   bus            : master-side and shared slave-side signals (arb modport)
//   grant_o        : one-hot current owner, 0 when idle
//   timeout_o      : one-cycle pulse on each watchdog abort
//   timeout_cnt_o  : saturating count of aborts since reset
module wbc_arbiter
  import wbc_pkg::*;
#(
  parameter int NM      = WBC_NM,
  parameter int AW      = WBC_AW,
  parameter int TIMEOUT = WBC_TIMEOUT
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  wbc_arbiter_if.arb    bus,
  output logic [NM-1:0] grant_o,
  output logic          timeout_o,
  output logic [7:0]    timeout_cnt_o
);

  localparam int          IW    = (NM > 1) ? $clog2(NM) : 1;
  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  wbc_state_e    state_r;
  logic [IW-1:0] gnt_idx_r;
  logic [IW-1:0] last_r;
  logic [NM-1:0] grant_r;
  logic [15:0]   wait_r;
  logic [7:0]    tcnt_r;

  logic [NM-1:0]     pick_gnt_s;
  logic [IW-1:0]     pick_idx_s;
  logic              pick_any_s;
  logic              own_s;
  logic              live_s;
  logic              unterm_s;
  logic              limit_s;
  logic [TERM_W-1:0] term_s;

  wbc_rr_pick #(.NM(NM)) u_pick (
    .req  (bus.m_cyc_i),
    .last (last_r),
    .gnt  (pick_gnt_s),
    .idx  (pick_idx_s),
    .any  (pick_any_s)
  );

  // Request mux: only the owner's fields reach the shared bus, and only in OWN
  // (ABORT and IDLE keep the slave side quiet).
  assign own_s       = (state_r == ST_OWN);
  assign bus.s_cyc_o = own_s & bus.m_cyc_i[gnt_idx_r];
  assign bus.s_stb_o = own_s & bus.m_stb_i[gnt_idx_r];
  assign bus.s_we_o  = own_s & bus.m_we_i[gnt_idx_r];
  assign bus.s_adr_o = own_s ? bus.m_adr_i[int'(gnt_idx_r)*AW +: AW] : '0;
  assign bus.s_dat_o = own_s ? bus.m_dat_i[int'(gnt_idx_r)*32 +: 32] : 32'd0;
  assign bus.s_sel_o = own_s ? bus.m_sel_i[int'(gnt_idx_r)*4 +: 4] : 4'd0;

  // Gather the slave terminations into one bundle.
  always_comb begin
    term_s           = '0;
    term_s[TERM_ACK] = bus.s_ack_i;
    term_s[TERM_ERR] = bus.s_err_i;
    term_s[TERM_RTY] = bus.s_rty_i;
  end

  // A termination in the limit cycle takes precedence over the abort.
  assign live_s   = bus.s_cyc_o & bus.s_stb_o;
  assign unterm_s = live_s & ~(|term_s);
  assign limit_s  = unterm_s & (wait_r == LIMIT);

  // grant_r is one-hot on the owner, so masking with it steers terminations.
  assign bus.m_ack_o = grant_r & {NM{live_s & term_s[TERM_ACK]}};
  assign bus.m_err_o = grant_r & {NM{(live_s & term_s[TERM_ERR]) | limit_s}};
  assign bus.m_rty_o = grant_r & {NM{live_s & term_s[TERM_RTY]}};
  assign bus.m_dat_o = bus.s_dat_i;

  assign grant_o       = grant_r;
  assign timeout_o     = limit_s;
  assign timeout_cnt_o = tcnt_r;

  // Arbiter FSM, ownership bookkeeping, watchdog and abort counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r   <= ST_IDLE;
      gnt_idx_r <= '0;
      last_r    <= IW'(NM - 1);
      grant_r   <= '0;
      wait_r    <= 16'd0;
      tcnt_r    <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          wait_r <= 16'd0;
          if (pick_any_s) begin
            grant_r   <= pick_gnt_s;
            gnt_idx_r <= pick_idx_s;
            state_r   <= ST_OWN;
          end else begin
            grant_r <= '0;
          end
        end
        ST_OWN: begin
          if (!bus.m_cyc_i[gnt_idx_r]) begin
            state_r <= ST_IDLE;
            grant_r <= '0;
            last_r  <= gnt_idx_r;
            wait_r  <= 16'd0;
          end else if (limit_s) begin
            state_r <= ST_ABORT;
            tcnt_r  <= sat_inc8(tcnt_r);
            wait_r  <= 16'd0;
          end else if (unterm_s) begin
            wait_r <= wait_r + 16'd1;
          end else begin
            // terminated or STB low: the wait restarts
            wait_r <= 16'd0;
          end
        end
        ST_ABORT: begin
          wait_r <= 16'd0;
          if (!bus.m_cyc_i[gnt_idx_r]) begin
            state_r <= ST_IDLE;
            grant_r <= '0;
            last_r  <= gnt_idx_r;
          end else begin
            state_r <= ST_ABORT;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          grant_r <= '0;
          wait_r  <= 16'd0;
        end
      endcase
    end
  end

endmodule
